// File: rtl/regfile_sb_bypass.sv
// Dual-read, dual-write integer register file with same-cycle bypass and a
// per-register pending scoreboard for decode-stage RAW hazard detection.
module regfile_sb_bypass #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 5,
   parameter bit          BYPASS  = 1'b1,
   parameter bit          ZERO_R0 = 1'b1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              i_wen_a,
   input  logic [ADDR_W-1:0] i_waddr_a,
   input  logic [DATA_W-1:0] i_wdata_a,
   input  logic              i_wen_b,
   input  logic [ADDR_W-1:0] i_waddr_b,
   input  logic [DATA_W-1:0] i_wdata_b,
   input  logic              i_iss_en,
   input  logic [ADDR_W-1:0] i_iss_addr,
   input  logic [ADDR_W-1:0] i_raddr1,
   input  logic [ADDR_W-1:0] i_raddr2,
   output logic [DATA_W-1:0] o_rdata1,
   output logic [DATA_W-1:0] o_rdata2,
   output logic              o_rbusy1,
   output logic              o_rbusy2
);

   localparam int unsigned NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [NREG];
   logic [NREG-1:0]   pend;

   logic wa_ok;
   logic wb_ok;
   logic iss_ok;

   // Qualified write/issue strobes; register 0 swallows them when hardwired.
   always_comb begin
      wa_ok  = i_wen_a  && !(ZERO_R0 && (i_waddr_a  == '0));
      wb_ok  = i_wen_b  && !(ZERO_R0 && (i_waddr_b  == '0));
      iss_ok = i_iss_en && !(ZERO_R0 && (i_iss_addr == '0));
   end

   // Data storage: port B wins on an address collision.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NREG; i++) begin
            if (wb_ok && (i_waddr_b == ADDR_W'(i))) begin
               mem[i] <= i_wdata_b;
            end else if (wa_ok && (i_waddr_a == ADDR_W'(i))) begin
               mem[i] <= i_wdata_a;
            end
         end
      end
   end

   // Scoreboard: a new issue outranks a retiring write to the same register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend <= '0;
      end else begin
         for (int unsigned i = 0; i < NREG; i++) begin
            if (iss_ok && (i_iss_addr == ADDR_W'(i))) begin
               pend[i] <= 1'b1;
            end else if ((wa_ok && (i_waddr_a == ADDR_W'(i))) ||
                         (wb_ok && (i_waddr_b == ADDR_W'(i)))) begin
               pend[i] <= 1'b0;
            end
         end
      end
   end

   function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      v = mem[a];
      if (BYPASS && wa_ok && (i_waddr_a == a)) v = i_wdata_a;
      if (BYPASS && wb_ok && (i_waddr_b == a)) v = i_wdata_b;
      if (ZERO_R0 && (a == '0)) v = '0;
      return v;
   endfunction

   function automatic logic rd_busy(input logic [ADDR_W-1:0] a);
      logic hit;
      hit = (wa_ok && (i_waddr_a == a)) || (wb_ok && (i_waddr_b == a));
      return pend[a] && !(BYPASS && hit);
   endfunction

   // Zero-latency read ports.
   always_comb begin
      o_rdata1 = rd_val(i_raddr1);
      o_rdata2 = rd_val(i_raddr2);
      o_rbusy1 = rd_busy(i_raddr1);
      o_rbusy2 = rd_busy(i_raddr2);
   end

endmodule

// File: tb/tb_regfile_sb_bypass.sv
// Bench for regfile_sb_bypass: a bypassing and a non-bypassing instance share
// stimulus and are compared against an array-based reference model.
module tb_regfile_sb_bypass;

   logic        clk;
   logic        rstn;
   logic        wen_a, wen_b, iss_en;
   logic [4:0]  waddr_a, waddr_b, iss_addr, raddr1, raddr2;
   logic [31:0] wdata_a, wdata_b;
   logic [31:0] rd1_y, rd2_y, rd1_n, rd2_n;
   logic        bz1_y, bz2_y, bz1_n, bz2_n;

   logic [31:0] m_mem [32];
   bit          m_pend [32];
   int          nerr;
   int          nchk;

   regfile_sb_bypass #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1), .ZERO_R0(1'b1)) u_byp (
      .clk(clk), .rstn(rstn),
      .i_wen_a(wen_a), .i_waddr_a(waddr_a), .i_wdata_a(wdata_a),
      .i_wen_b(wen_b), .i_waddr_b(waddr_b), .i_wdata_b(wdata_b),
      .i_iss_en(iss_en), .i_iss_addr(iss_addr),
      .i_raddr1(raddr1), .i_raddr2(raddr2),
      .o_rdata1(rd1_y), .o_rdata2(rd2_y), .o_rbusy1(bz1_y), .o_rbusy2(bz2_y));

   regfile_sb_bypass #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0), .ZERO_R0(1'b1)) u_nobyp (
      .clk(clk), .rstn(rstn),
      .i_wen_a(wen_a), .i_waddr_a(waddr_a), .i_wdata_a(wdata_a),
      .i_wen_b(wen_b), .i_waddr_b(waddr_b), .i_wdata_b(wdata_b),
      .i_iss_en(iss_en), .i_iss_addr(iss_addr),
      .i_raddr1(raddr1), .i_raddr2(raddr2),
      .o_rdata1(rd1_n), .o_rdata2(rd2_n), .o_rbusy1(bz1_n), .o_rbusy2(bz2_n));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Architectural expectation of a read, from the register-file rules.
   function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (byp && wen_b && waddr_b == a) return wdata_b;
      if (byp && wen_a && waddr_a == a) return wdata_a;
      return m_mem[a];
   endfunction

   function automatic logic [31:0] exp_bz(input bit byp, input logic [4:0] a);
      bit wr;
      if (a == 5'd0) return 32'h0;
      wr = (wen_a && waddr_a == a) || (wen_b && waddr_b == a);
      return (m_pend[a] && !(byp && wr)) ? 32'h1 : 32'h0;
   endfunction

   task automatic check_model(input string tag);
      chk({tag, ".byp.rd1"}, rd1_y, exp_rd(1'b1, raddr1));
      chk({tag, ".byp.rd2"}, rd2_y, exp_rd(1'b1, raddr2));
      chk({tag, ".byp.bz1"}, 32'(bz1_y), exp_bz(1'b1, raddr1));
      chk({tag, ".byp.bz2"}, 32'(bz2_y), exp_bz(1'b1, raddr2));
      chk({tag, ".nob.rd1"}, rd1_n, exp_rd(1'b0, raddr1));
      chk({tag, ".nob.rd2"}, rd2_n, exp_rd(1'b0, raddr2));
      chk({tag, ".nob.bz1"}, 32'(bz1_n), exp_bz(1'b0, raddr1));
      chk({tag, ".nob.bz2"}, 32'(bz2_n), exp_bz(1'b0, raddr2));
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         m_mem[i]  = 32'h0;
         m_pend[i] = 1'b0;
      end
   endtask

   // Advance one clock edge, applying writes then issues to the model.
   task automatic tick();
      @(posedge clk);
      if (rstn) begin
         if (wen_a && waddr_a != 5'd0) begin m_mem[waddr_a] = wdata_a; m_pend[waddr_a] = 1'b0; end
         if (wen_b && waddr_b != 5'd0) begin m_mem[waddr_b] = wdata_b; m_pend[waddr_b] = 1'b0; end
         if (iss_en && iss_addr != 5'd0) m_pend[iss_addr] = 1'b1;
      end
      #1;
   endtask

   task automatic idle();
      wen_a = 1'b0; waddr_a = '0; wdata_a = '0;
      wen_b = 1'b0; waddr_b = '0; wdata_b = '0;
      iss_en = 1'b0; iss_addr = '0;
   endtask

   task automatic sweep_zero(input string tag);
      for (int a = 0; a < 32; a++) begin
         raddr1 = 5'(a);
         raddr2 = 5'(31 - a);
         #1;
         chk({tag, ".byp.rd1"}, rd1_y, 32'h0);
         chk({tag, ".byp.bz2"}, 32'(bz2_y), 32'h0);
         chk({tag, ".nob.rd2"}, rd2_n, 32'h0);
         chk({tag, ".nob.bz1"}, 32'(bz1_n), 32'h0);
      end
   endtask

   initial begin
      nerr = 0;
      nchk = 0;
      rstn = 1'b0;
      idle();
      raddr1 = '0;
      raddr2 = '0;
      model_clear();
      #12;
      sweep_zero("reset");
      @(negedge clk) rstn = 1'b1;
      @(posedge clk);
      #1;

      // Basic write/read through port A.
      wen_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'h12345678; raddr1 = 5'd5; raddr2 = 5'd6;
      #2; check_model("wr_a");
      tick(); idle();
      #2; check_model("rd_x5");
      chk("rd_x5.byp", rd1_y, 32'h12345678);
      chk("rd_x5.nob", rd1_n, 32'h12345678);
      tick();

      // Hardwired zero: write and issue to x0.
      wen_b = 1'b1; waddr_b = 5'd0; wdata_b = 32'hFFFFFFFF; iss_en = 1'b1; iss_addr = 5'd0; raddr1 = 5'd0;
      #2; chk("x0_bypass", rd1_y, 32'h0); check_model("x0_wr");
      tick(); idle();
      #2; chk("x0_read", rd1_n, 32'h0); chk("x0_busy", 32'(bz1_y), 32'h0);
      tick();

      // Same-address collision: port B wins.
      wen_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h1111;
      wen_b = 1'b1; waddr_b = 5'd7; wdata_b = 32'h2222; raddr2 = 5'd7;
      #2; chk("coll_byp", rd2_y, 32'h2222); check_model("coll");
      tick(); idle();
      #2; chk("coll_nob", rd2_n, 32'h2222); check_model("coll_rd");
      tick();

      // Bypass vs. non-bypass visibility timing.
      wen_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'hCAFE; raddr1 = 5'd3;
      #2; chk("byp_same", rd1_y, 32'hCAFE); chk("nob_same", rd1_n, 32'h0);
      tick(); idle();
      #2; chk("nob_next", rd1_n, 32'hCAFE);
      tick();

      // Scoreboard hazard sequence on x9.
      iss_en = 1'b1; iss_addr = 5'd9; raddr1 = 5'd9;
      #2; chk("iss_same_cyc", 32'(bz1_y), 32'h0); check_model("iss");
      tick(); idle();
      #2; chk("iss_busy_byp", 32'(bz1_y), 32'h1); chk("iss_busy_nob", 32'(bz1_n), 32'h1);
      tick();
      wen_b = 1'b1; waddr_b = 5'd9; wdata_b = 32'hBEEF;
      #2; chk("wb_clr_bz", 32'(bz1_y), 32'h0); chk("wb_clr_rd", rd1_y, 32'hBEEF);
      chk("wb_nob_bz", 32'(bz1_n), 32'h1);
      tick(); idle();
      #2; chk("wb_after", 32'(bz1_n), 32'h0); check_model("wb_after");
      tick();
      iss_en = 1'b1; iss_addr = 5'd9; wen_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'h55;
      tick(); idle();
      #2; chk("iss_wins_byp", 32'(bz1_y), 32'h1); chk("iss_wins_nob", 32'(bz1_n), 32'h1);
      chk("iss_wins_rd", rd1_n, 32'h55);
      tick();

      // Randomised traffic with a bias towards a few hot registers.
      for (int n = 0; n < 400; n++) begin
         wen_a    = 1'($urandom_range(0, 1));
         waddr_a  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         wdata_a  = $urandom;
         wen_b    = 1'($urandom_range(0, 1));
         waddr_b  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         wdata_b  = $urandom;
         iss_en   = 1'($urandom_range(0, 1));
         iss_addr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         raddr1   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         raddr2   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         #2; check_model("rand");
         tick();
      end

      // Asynchronous reset between edges, after fresh state in x12/x13.
      idle();
      iss_en = 1'b1; iss_addr = 5'd12; wen_a = 1'b1; waddr_a = 5'd13; wdata_a = 32'hA5A5A5A5;
      tick(); idle();
      raddr1 = 5'd12; raddr2 = 5'd13;
      #2; chk("pre_rst_bz", 32'(bz1_n), 32'h1); chk("pre_rst_rd", rd2_n, 32'hA5A5A5A5);
      #1 rstn = 1'b0;
      model_clear();
      #1;
      chk("async_bz", 32'(bz1_n), 32'h0); chk("async_rd", rd2_n, 32'h0);
      chk("async_bz_byp", 32'(bz1_y), 32'h0); chk("async_rd_byp", rd2_y, 32'h0);
      sweep_zero("midrst");

      // Writes and issues during reset are ignored.
      @(negedge clk);
      wen_a = 1'b1; waddr_a = 5'd4; wdata_a = 32'hDEAD; iss_en = 1'b1; iss_addr = 5'd4;
      tick(); idle();
      @(negedge clk) rstn = 1'b1;
      raddr1 = 5'd4;
      #1;
      chk("rst_wr_ign", rd1_n, 32'h0); chk("rst_iss_ign", 32'(bz1_y), 32'h0);
      check_model("post_rst");

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
